// File: rtl/wimax_pkg.sv
// Shared constants and types for the WiMax symbol framer.
// Build with WIMAX_FRAMER_PILOT_EN defined to append a pilot after every PILOT_SPACING data symbols.
package wimax_pkg;
    localparam int DW            = 16;
    localparam int NSYM          = 96;
    localparam int PILOT_SPACING = 12;
    localparam logic [DW-1:0] PILOT_VAL = 16'h5A82;
`ifdef WIMAX_FRAMER_PILOT_EN
    localparam int FRAME_LEN = NSYM + NSYM / PILOT_SPACING;
`else
    localparam int FRAME_LEN = NSYM;
`endif
    localparam int AW = $clog2(NSYM);
    localparam int PW = $clog2(PILOT_SPACING);

    typedef struct packed {
        logic [DW-1:0] I;
        logic [DW-1:0] Q;
    } iq_t;

    typedef enum logic {IDLE, READ} rd_state_t;
endpackage

// File: rtl/wimax_pingpong_ram.sv
// Two-bank symbol store: one synchronous write port, one synchronous read port.
// The read data register doubles as the framer's output data register.
module wimax_pingpong_ram
    import wimax_pkg::*;
(
    input  logic          clk_ref,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  iq_t           wr_data_i,
    input  logic          re_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output iq_t           rd_data_o
);
    iq_t mem [2][NSYM];

    always_ff @(posedge clk_ref) begin
        if (we_i) mem[wr_bank_i][wr_addr_i] <= wr_data_i;
    end

    // Held when re_i is low, so a stalled output symbol stays stable.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n)    rd_data_o <= '0;
        else if (re_i) rd_data_o <= mem[rd_bank_i][rd_addr_i];
    end
endmodule

// File: rtl/wimax_symbol_framer.sv
// Ping-pong block framer: collects NSYM I/Q symbols per bank and replays each bank as a sof/eof framed stream.
// Optional pilot insertion is enabled by defining WIMAX_FRAMER_PILOT_EN.
module wimax_symbol_framer
    import wimax_pkg::*;
(
    input  logic          clk_ref,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_I,
    input  logic [DW-1:0] in_Q,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_I,
    output logic [DW-1:0] out_Q,
    output logic          out_sof,
    output logic          out_eof,
    output logic          overflow
);
    localparam logic [AW-1:0] LAST = AW'(NSYM - 1);

    logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [1:0]    full_q, full_d;
    rd_state_t     state_q, state_d;
    logic          out_valid_q, out_valid_d, sof_q, sof_d, eof_q, eof_d, ovf_q, ovf_d;
    logic          accept, can_adv, data_load, load, rd_last;
    iq_t           rd_iq;
`ifdef WIMAX_FRAMER_PILOT_EN
    localparam logic [PW-1:0] PLAST = PW'(PILOT_SPACING - 1);
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          pend_q, pend_d, peof_q, peof_d, pilot_q, pilot_d, pilot_load;
`endif

    always_comb begin
        in_ready = !full_q[wr_sel_q];
        accept   = in_valid & in_ready;
        can_adv  = !out_valid_q | out_ready;
`ifdef WIMAX_FRAMER_PILOT_EN
        pilot_load = can_adv & pend_q;
        data_load  = can_adv & !pend_q & full_q[rd_sel_q];
        load       = data_load | pilot_load;
`else
        data_load  = can_adv & full_q[rd_sel_q];
        load       = data_load;
`endif
        rd_last = data_load & (rd_cnt_q == LAST);
    end

    // Writer and reader always own different banks, so both may update full_d in one cycle.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        rd_cnt_d = rd_cnt_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        ovf_d    = ovf_q | (in_valid & !in_ready);
        if (accept) begin
            if (wr_cnt_q == LAST) begin
                wr_cnt_d         = '0;
                wr_sel_d         = !wr_sel_q;
                full_d[wr_sel_q] = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end
        if (data_load) begin
            if (rd_last) begin
                rd_cnt_d         = '0;
                rd_sel_d         = !rd_sel_q;
                full_d[rd_sel_q] = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = load | (out_valid_q & !out_ready);
        sof_d       = sof_q;
        eof_d       = eof_q;
`ifdef WIMAX_FRAMER_PILOT_EN
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;
        peof_d  = peof_q;
        pilot_d = load ? pilot_load : pilot_q;
        if (pilot_load) begin
            pend_d = 1'b0;
            peof_d = 1'b0;
        end
        if (data_load) begin
            if (pcnt_q == PLAST) begin
                pcnt_d = '0;
                pend_d = 1'b1;
                peof_d = rd_last;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
        // The bank is released on its last data symbol; the frame ends on the trailing pilot.
        case (state_q)
            IDLE:    if (data_load) state_d = READ;
            default: if (pilot_load && peof_q) state_d = full_q[rd_sel_q] ? READ : IDLE;
        endcase
        if (load) begin
            sof_d = data_load & (rd_cnt_q == '0);
            eof_d = pilot_load & peof_q;
        end
`else
        case (state_q)
            IDLE:    if (data_load && !rd_last) state_d = READ;
            default: if (rd_last) state_d = full_q[!rd_sel_q] ? READ : IDLE;
        endcase
        if (load) begin
            sof_d = (rd_cnt_q == '0);
            eof_d = rd_last;
        end
`endif
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef WIMAX_FRAMER_PILOT_EN
            pcnt_q      <= '0;
            pend_q      <= 1'b0;
            peof_q      <= 1'b0;
            pilot_q     <= 1'b0;
`endif
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            ovf_q       <= ovf_d;
`ifdef WIMAX_FRAMER_PILOT_EN
            pcnt_q      <= pcnt_d;
            pend_q      <= pend_d;
            peof_q      <= peof_d;
            pilot_q     <= pilot_d;
`endif
        end
    end

    wimax_pingpong_ram u_ram (
        .clk_ref   (clk_ref),
        .rst_n     (rst_n),
        .we_i      (accept),
        .wr_bank_i (wr_sel_q),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i ({in_I, in_Q}),
        .re_i      (data_load),
        .rd_bank_i (rd_sel_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (rd_iq)
    );

    assign out_valid = out_valid_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;
    assign overflow  = ovf_q;
`ifdef WIMAX_FRAMER_PILOT_EN
    assign out_I = pilot_q ? PILOT_VAL : rd_iq.I;
    assign out_Q = pilot_q ? '0 : rd_iq.Q;
`else
    assign out_I = rd_iq.I;
    assign out_Q = rd_iq.Q;
`endif
endmodule

// File: doc/wimax_symbol_framer.md
Name: wimax_symbol_framer

Overview:
- Downstream stage of the WiMax transmit chain. Consumes QPSK I/Q symbols from the modulator output: valid_out, data_out_I, data_out_Q.
- Collects symbols into fixed-size blocks in a two-bank ping-pong buffer, then re-emits each block as a framed stream with sof/eof markers and valid/ready backpressure.
- Decouples the always-valid modulator from a stallable consumer (IFFT / sink), and reports dropped symbols.

Parameters:
- NSYM, 96: data symbols per block (one FEC block at Ncpc=2).
- DW, 16: width of each I and Q sample.
- PILOT_SPACING, 12: data symbols between inserted pilots. Used only with the optional feature; must divide NSYM.
- PILOT_VAL, 16'h5A82: I value of a pilot symbol; pilot Q is 0.

Ports:
- clk_ref  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  symbol present (modulator valid_out).
- in_I  in  DW  input I sample.
- in_Q  in  DW  input Q sample.
- in_ready  out  1  writer bank can accept a symbol.
- out_valid  out  1  output symbol present.
- out_ready  in  1  consumer accepts the output symbol.
- out_I  out  DW  output I sample.
- out_Q  out  DW  output Q sample.
- out_sof  out  1  first symbol of the frame.
- out_eof  out  1  last symbol of the frame.
- overflow  out  1  sticky: at least one symbol dropped.

Behaviour:
- Reset, asynchronous and active-low:
  - wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0, both bank full flags 0, read FSM in IDLE.
  - Outputs: in_ready=1, out_valid=0, out_I/out_Q=0, out_sof=0, out_eof=0, overflow=0.
  - Buffer contents are don't-care.
  - Reset mid-block discards any partial or full bank, with no output.
- Handshakes:
  - Accept = in_valid & in_ready.
  - in_ready = !full[wr_sel], driven combinationally from registered state.
- Write side:
  - Each accept writes bank[wr_sel][wr_cnt], then increments wr_cnt.
  - On the accept with wr_cnt==NSYM-1: set full[wr_sel], wr_cnt<=0, toggle wr_sel.
- Drop rule: in_valid & !in_ready drops the symbol and sets overflow. overflow is cleared only by reset.
- Read FSM states and transitions:
  - IDLE: leave for READ when full[rd_sel]==1.
  - READ: the read address advances only when the output register is empty or being consumed (out_valid & out_ready).
  - On loading the last entry: clear full[rd_sel], toggle rd_sel, return to IDLE.
  - If full of the new rd_sel is already set, go directly back to READ with no bubble.
- Output register: out_I, out_Q, out_sof and out_eof are held stable while out_valid & !out_ready.
- Latency: out_valid rises on the first clk_ref edge after the edge that accepted symbol NSYM-1. This holds when no earlier frame is pending.
- Throughput:
  - With out_ready held at 1, the bank is freed on the same edge its last entry is loaded.
  - A continuous 1 symbol/clk input therefore never stalls.
- Simultaneous events:
  - Bank freed and writer needing that bank in the same cycle: the writer sees the bank free from the next cycle; in_ready is low for that one cycle only.
  - Reader and writer never touch the same bank.
- Framing:
  - out_sof=1 on symbol index 0 of the frame; out_eof=1 on the final symbol.
  - Both are 0 otherwise, and both may be 1 only if the frame length is 1.

Optional Feature:
- Macro: WIMAX_FRAMER_PILOT_EN.
- Defined: after every PILOT_SPACING data symbols the reader emits one pilot symbol (I=PILOT_VAL, Q=0) without advancing the read address.
  - The final pilot falls after the last data symbol and carries out_eof.
  - Frame length is NSYM + NSYM/PILOT_SPACING (104 at defaults).
  - Sustained input rate must be at most NSYM/frame length, otherwise overflow is expected.
- Undefined: no pilots; frame length is NSYM; no pilot counter logic is present.

Decomposition:
- Package wimax_pkg holds:
  - DW, NSYM, PILOT_VAL, and FRAME_LEN as constants;
  - typedef iq_t, a struct of logic [DW-1:0] I and Q;
  - typedef enum rd_state_t {IDLE, READ}.
- Sub-module wimax_pingpong_ram: two banks of NSYM x 2*DW, one synchronous write port and one synchronous read port, with a bank-select bit per port. No reset on the array.

Test Plan:
- Reset, then 96 symbols on consecutive clocks with in_I=k, in_Q=16'hFFFF-k and out_ready=1 → 96 outputs in order; out_sof with I=0, out_eof with I=95; out_valid on the edge after the last accept; overflow=0.
- 960 symbols continuous (10 blocks), out_ready=1 → in_ready never low; 10 frames back-to-back with no gap; overflow=0.
- out_ready=0 while 192 symbols are fed → in_ready falls after the 192nd accept; the 193rd in_valid sets overflow=1. Then out_ready=1 → both frames emitted intact.
- out_ready toggling 1,0,1,0 during a frame → no symbol lost or duplicated; outputs stable while stalled.
- rst_n pulsed low after 50 symbols, then 96 fresh symbols → only the fresh frame emitted; sof aligns to the first post-reset symbol.
- With WIMAX_FRAMER_PILOT_EN → 104-symbol frame; positions 12, 25, …, 103 carry I=16'h5A82, Q=0; eof on position 103.
